// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports,
// same-cycle write-to-read forwarding, a per-register busy scoreboard for
// issue-stage hazard detection, and a post-reset sequencer that clears
// every register before the core is allowed to run.
module regfile_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               o_init_done,
  input  logic               i_we0,
  input  logic [AW-1:0]      i_waddr0,
  input  logic [DW-1:0]      i_wdata0,
  input  logic               i_we1,
  input  logic [AW-1:0]      i_waddr1,
  input  logic [DW-1:0]      i_wdata1,
  input  logic [NR-1:0]      i_re,
  input  logic [NR*AW-1:0]   i_raddr,
  output logic [NR*DW-1:0]   o_rdata,
  output logic [NR-1:0]      o_busy,
  input  logic               i_set_en,
  input  logic [AW-1:0]      i_set_addr
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cntNext;
  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busyNext;
  logic             w_run;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_set;

  // Writes and scoreboard sets only count once the clear sequence is done;
  // address 0 is hardwired to zero so writes or sets there are dropped.
  assign w_run       = (r_state == ST_RUN);
  assign o_init_done = w_run;
  assign w_wr0       = w_run && i_we0 && (i_waddr0 != '0);
  assign w_wr1       = w_run && i_we1 && (i_waddr1 != '0);
  assign w_set       = w_run && i_set_en && (i_set_addr != '0);

  // State register and clear counter; reset restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next state: INIT walks every address once, then RUN holds until reset.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cntNext = r_cnt + 1'b1;
        if (r_cnt == {AW{1'b1}}) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        w_stateNext = ST_RUN;
      end
      default: begin
        w_stateNext = ST_INIT;
      end
    endcase
  end

  // Storage: zero one entry per INIT cycle, otherwise accept both write
  // ports with port 1 ordered last so the younger instruction wins a clash.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_regs[r_cnt] <= '0;
      end else begin
        if (w_wr0) begin
          r_regs[i_waddr0] <= i_wdata0;
        end
        if (w_wr1) begin
          r_regs[i_waddr1] <= i_wdata1;
        end
      end
    end
  end

  // Scoreboard update: retiring writes clear, a new producer sets last so
  // it supersedes a retirement to the same register.
  always_comb begin
    w_busyNext = r_busy;
    if (w_wr0) begin
      w_busyNext[i_waddr0] = 1'b0;
    end
    if (w_wr1) begin
      w_busyNext[i_waddr1] = 1'b0;
    end
    if (w_set) begin
      w_busyNext[i_set_addr] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  // Scoreboard register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  // Read ports: disabled/zero/INIT reads return 0, then forward port 1,
  // then port 0, then the stored value. A register being written this
  // cycle is reported not-busy because its data is already forwarded.
  for (genvar g = 0; g < NR; g++) begin : g_port
    logic [AW-1:0] w_raddr;
    logic          w_valid;
    logic          w_fwd0;
    logic          w_fwd1;

    assign w_raddr = i_raddr[g*AW +: AW];
    assign w_valid = w_run && i_re[g] && (w_raddr != '0);
    assign w_fwd1  = w_wr1 && (i_waddr1 == w_raddr);
    assign w_fwd0  = w_wr0 && (i_waddr0 == w_raddr);

    assign o_rdata[g*DW +: DW] = !w_valid ? '0 :
                                 w_fwd1   ? i_wdata1 :
                                 w_fwd0   ? i_wdata0 :
                                 r_regs[w_raddr];
    assign o_busy[g] = w_valid && r_busy[w_raddr] && !w_fwd0 && !w_fwd1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp, one instance with
// default parameters and one with NR=4, AW=3, DW=16.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance signals
  logic        aRst;
  logic        aInitDone;
  logic        aWe0;
  logic [4:0]  aWaddr0;
  logic [31:0] aWdata0;
  logic        aWe1;
  logic [4:0]  aWaddr1;
  logic [31:0] aWdata1;
  logic [1:0]  aRe;
  logic [9:0]  aRaddr;
  logic [63:0] aRdata;
  logic [1:0]  aBusy;
  logic        aSetEn;
  logic [4:0]  aSetAddr;

  // Small-parameter instance signals
  logic        bRst;
  logic        bInitDone;
  logic        bWe0;
  logic [2:0]  bWaddr0;
  logic [15:0] bWdata0;
  logic        bWe1;
  logic [2:0]  bWaddr1;
  logic [15:0] bWdata1;
  logic [3:0]  bRe;
  logic [11:0] bRaddr;
  logic [63:0] bRdata;
  logic [3:0]  bBusy;
  logic        bSetEn;
  logic [2:0]  bSetAddr;

  regfile_mp dutA (
    .clk(clk), .rst(aRst), .o_init_done(aInitDone),
    .i_we0(aWe0), .i_waddr0(aWaddr0), .i_wdata0(aWdata0),
    .i_we1(aWe1), .i_waddr1(aWaddr1), .i_wdata1(aWdata1),
    .i_re(aRe), .i_raddr(aRaddr), .o_rdata(aRdata), .o_busy(aBusy),
    .i_set_en(aSetEn), .i_set_addr(aSetAddr)
  );

  regfile_mp #(.DW(16), .AW(3), .NR(4)) dutB (
    .clk(clk), .rst(bRst), .o_init_done(bInitDone),
    .i_we0(bWe0), .i_waddr0(bWaddr0), .i_wdata0(bWdata0),
    .i_we1(bWe1), .i_waddr1(bWaddr1), .i_wdata1(bWdata1),
    .i_re(bRe), .i_raddr(bRaddr), .o_rdata(bRdata), .o_busy(bBusy),
    .i_set_en(bSetEn), .i_set_addr(bSetAddr)
  );

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        setEn;
    logic [4:0]  setAddr;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
    logic [1:0]  expBusy;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   cycles;

  task automatic expectVal(input string n, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-empty actual=%h", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("[TB] FAIL %s actual=%h required=%h", e.name, act, e.val);
      end
    end
  endtask

  task automatic idleA();
    aWe0 = 0; aWaddr0 = 0; aWdata0 = 0;
    aWe1 = 0; aWaddr1 = 0; aWdata1 = 0;
    aRe = 0; aRaddr = 0; aSetEn = 0; aSetAddr = 0;
  endtask

  task automatic idleB();
    bWe0 = 0; bWaddr0 = 0; bWdata0 = 0;
    bWe1 = 0; bWaddr1 = 0; bWdata1 = 0;
    bRe = 0; bRaddr = 0; bSetEn = 0; bSetAddr = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    aWe0 = v.we0; aWaddr0 = v.wa0; aWdata0 = v.wd0;
    aWe1 = v.we1; aWaddr1 = v.wa1; aWdata1 = v.wd1;
    aRe = v.re; aRaddr = {v.ra1, v.ra0};
    aSetEn = v.setEn; aSetAddr = v.setAddr;
  endtask

  // Counts negedges with init_done low; optionally injects a write and a
  // set on instance A at INIT cycle injectAt, which must be ignored.
  task automatic countInit(input bit useB, input int injectAt, output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((useB ? bInitDone : aInitDone) == 1'b1) break;
      n++;
      if (!useB && c == injectAt) begin
        aWe0 = 1; aWaddr0 = 5'd5; aWdata0 = 32'hDEADBEEF;
        aSetEn = 1; aSetAddr = 5'd5;
      end else if (!useB) begin
        aWe0 = 0; aSetEn = 0;
      end
    end
    if (!useB) idleA();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idleA();
    idleB();
    aRst = 1;
    bRst = 1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    expectVal("reset-init_done", 0);
    checkOutput({63'd0, aInitDone});
    expectVal("reset-busy", 0);
    checkOutput({62'd0, aBusy});
    @(posedge clk);
    #1 aRst = 0;

    // Init length with an ignored write/set to r5
    countInit(0, 4, cycles);
    expectVal("initA-length", 32);
    checkOutput(64'(cycles));
    expectVal("initA-done", 1);
    checkOutput({63'd0, aInitDone});

    // All registers cleared, r5 write dropped, r5 not busy
    for (int a = 1; a < 32; a++) begin
      @(posedge clk);
      #1 aRe = 2'b01; aRaddr = {5'd0, 5'(a)};
      @(negedge clk);
      expectVal($sformatf("cleared-r%0d", a), 0);
      checkOutput({32'd0, aRdata[31:0]});
      if (a == 5) begin
        expectVal("busy-r5-after-init", 0);
        checkOutput({62'd0, aBusy});
      end
    end

    // Fields: we0 wa0 wd0 we1 wa1 wd1 re ra0 ra1 setEn setAddr expRd0 expRd1 expBusy
    vecs.push_back('{1, 7, 32'h11111111, 1, 7, 32'h22222222, 2'b01, 7, 0, 0, 0, 32'h22222222, 0, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 7, 7, 0, 0, 32'h22222222, 32'h22222222, 2'b00});
    vecs.push_back('{1, 3, 32'hA, 1, 4, 32'hB, 2'b11, 3, 4, 0, 0, 32'hA, 32'hB, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 3, 4, 0, 0, 32'hA, 32'hB, 2'b00});
    vecs.push_back('{1, 0, 32'hFFFFFFFF, 0, 0, 0, 2'b11, 0, 0, 1, 0, 0, 0, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 1, 9, 0, 0, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 0, 0, 2'b01});
    vecs.push_back('{1, 9, 32'h55, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h55, 32'h55, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h55, 32'h55, 2'b00});
    vecs.push_back('{0, 0, 0, 1, 9, 32'h66, 2'b01, 9, 0, 1, 9, 32'h66, 0, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 9, 7, 0, 0, 32'h66, 32'h22222222, 2'b01});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b10, 9, 9, 0, 0, 0, 32'h66, 2'b10});
    vecs.push_back('{1, 9, 32'h77, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h77, 32'h77, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 9, 3, 0, 0, 32'h77, 32'hA, 2'b00});
    vecs.push_back('{1, 3, 32'hC, 1, 9, 32'h88, 2'b11, 3, 4, 0, 0, 32'hC, 32'hB, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2'b11, 3, 9, 0, 0, 32'hC, 32'h88, 2'b00});

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      expectVal($sformatf("vec%0d-rdata0", i), {32'd0, vecs[i].expRd0});
      expectVal($sformatf("vec%0d-rdata1", i), {32'd0, vecs[i].expRd1});
      expectVal($sformatf("vec%0d-busy", i), {62'd0, vecs[i].expBusy});
      @(negedge clk);
      checkOutput({32'd0, aRdata[31:0]});
      checkOutput({32'd0, aRdata[63:32]});
      checkOutput({62'd0, aBusy});
    end

    // Reset mid-operation: populate r2/r14, mark r6 busy
    @(posedge clk);
    #1 idleA();
    aWe0 = 1; aWaddr0 = 5'd2; aWdata0 = 32'h1234;
    aWe1 = 1; aWaddr1 = 5'd14; aWdata1 = 32'hABCD;
    aSetEn = 1; aSetAddr = 5'd6;
    @(posedge clk);
    #1 idleA();
    aRe = 2'b11; aRaddr = {5'd6, 5'd2};
    @(negedge clk);
    expectVal("pre-reset-r2", 32'h1234);
    checkOutput({32'd0, aRdata[31:0]});
    expectVal("pre-reset-busy-r6", 2'b10);
    checkOutput({62'd0, aBusy});
    @(posedge clk);
    #1 aRst = 1;
    @(posedge clk);
    #1 aRst = 0;
    @(posedge clk);
    @(posedge clk);
    #1 aRe = 2'b01; aRaddr = {5'd0, 5'd14};
    aWe1 = 1; aWaddr1 = 5'd14; aWdata1 = 32'hFFFFFFFF;
    aSetEn = 1; aSetAddr = 5'd14;
    @(negedge clk);
    expectVal("init-read-r14", 0);
    checkOutput({32'd0, aRdata[31:0]});
    expectVal("init-busy", 0);
    checkOutput({62'd0, aBusy});
    expectVal("init-done-low", 0);
    checkOutput({63'd0, aInitDone});
    @(posedge clk);
    #1 idleA();
    repeat (7) @(posedge clk);
    #1 aRst = 1;
    @(posedge clk);
    #1 aRst = 0;
    countInit(0, -1, cycles);
    expectVal("reinit-length", 32);
    checkOutput(64'(cycles));
    @(posedge clk);
    #1 aRe = 2'b11; aRaddr = {5'd6, 5'd2};
    @(negedge clk);
    expectVal("post-reset-r2", 0);
    checkOutput({32'd0, aRdata[31:0]});
    expectVal("post-reset-busy-r6", 0);
    checkOutput({62'd0, aBusy});
    @(posedge clk);
    #1 aRaddr = {5'd14, 5'd14};
    @(negedge clk);
    expectVal("post-reset-r14", 0);
    checkOutput(aRdata);

    // Small-parameter instance
    @(posedge clk);
    #1 bRst = 0;
    countInit(1, -1, cycles);
    expectVal("initB-length", 8);
    checkOutput(64'(cycles));
    @(posedge clk);
    #1 bWe0 = 1; bWaddr0 = 3'd1; bWdata0 = 16'h0001;
    bWe1 = 1; bWaddr1 = 3'd2; bWdata1 = 16'h0002;
    @(posedge clk);
    #1 bWaddr0 = 3'd3; bWdata0 = 16'h0003;
    bWaddr1 = 3'd4; bWdata1 = 16'h0004;
    bRe = 4'b1111; bRaddr = {3'd4, 3'd3, 3'd2, 3'd1};
    @(negedge clk);
    expectVal("B-fwd-read4", 64'h0004_0003_0002_0001);
    checkOutput(bRdata);
    @(posedge clk);
    #1 bWe0 = 0; bWe1 = 0;
    bSetEn = 1; bSetAddr = 3'd3;
    @(negedge clk);
    expectVal("B-stored-read4", 64'h0004_0003_0002_0001);
    checkOutput(bRdata);
    expectVal("B-busy-none", 0);
    checkOutput({60'd0, bBusy});
    @(posedge clk);
    #1 bSetEn = 0; bRe = 4'b0101;
    @(negedge clk);
    expectVal("B-re0101", 64'h0000_0003_0000_0001);
    checkOutput(bRdata);
    expectVal("B-busy-re0101", 4'b0100);
    checkOutput({60'd0, bBusy});
    @(posedge clk);
    #1 bRe = 4'b1111;
    @(negedge clk);
    expectVal("B-busy-r3", 4'b0100);
    checkOutput({60'd0, bBusy});

    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-leftover actual=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
